// File: rtl/rowbuff_pkg.sv
// Shared definitions for the row-buffer slice: sequencer states, sizing helper and default geometry.
// Also used by the row buffer and the matrix unit, which share the COLUMN_SIZE default.
package rowbuff_pkg;

    localparam int DEFAULT_COLUMN_SIZE    = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        FLUSH    = 3'd2,
        WAIT_SET = 3'd3,
        HANDOFF  = 3'd4,
        WAIT_MAT = 3'd5
    } state_t;

    // Ceiling log2, floored at 1 so every counter built from it has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rowbuff_seq_ctrl_if.sv
// Control-only bus between the sequencer, the row source, the row buffer and the matrix unit.
// master = sequencer side, slave = the surrounding blocks.
interface rowbuff_seq_ctrl_if;

    logic row_valid;
    logic row_last;
    logic row_ready;
    logic buf_enable;
    logic buf_dend;
    logic buf_dset;
    logic mat_start;
    logic mat_done;

    modport master (
        input  row_valid, row_last, buf_dset, mat_done,
        output row_ready, buf_enable, buf_dend, mat_start
    );

    modport slave (
        output row_valid, row_last, buf_dset, mat_done,
        input  row_ready, buf_enable, buf_dend, mat_start
    );

endinterface

// File: rtl/rowbuff_seq_wdog.sv
// WAIT_SET watchdog: counts consecutive cycles with run high and flags the last allowed one.
// Only instantiated when ROWBUFF_SEQ_TIMEOUT_EN is defined.
module rowbuff_seq_wdog
    import rowbuff_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int            CW         = clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = run ? (count_q + CW'(1)) : '0;
    end

    // High during the TIMEOUT_CYCLES-th consecutive cycle of run.
    assign expired = run && (count_q == LAST_COUNT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rowbuff_seq_ctrl.sv
// Row-buffer sequencer: row intake, end-of-data flush, wait for set, matrix handoff. Carries no data.
// Optional WAIT_SET watchdog is built in when ROWBUFF_SEQ_TIMEOUT_EN is defined.
module rowbuff_seq_ctrl
    import rowbuff_pkg::*;
#(
    parameter int COLUMN_SIZE    = DEFAULT_COLUMN_SIZE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    rowbuff_seq_ctrl_if.master          bus,
    output logic                        busy,
    output logic [clog2(COLUMN_SIZE):0] rows_loaded,
    output logic                        err_overrun,
    output logic                        err_timeout
);

    localparam int            RW         = clog2(COLUMN_SIZE) + 1;
    localparam logic [RW-1:0] FULL_COUNT = RW'(COLUMN_SIZE);
    localparam logic [RW-1:0] ONE        = RW'(1);

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [RW-1:0] rows_loaded_q, rows_loaded_d;
    logic [RW-1:0] rows_inc;
    logic          row_ready_q, row_ready_d;
    logic          buf_enable_q, buf_enable_d;
    logic          buf_dend_q, buf_dend_d;
    logic          mat_start_q, mat_start_d;
    logic          busy_q, busy_d;
    logic          err_overrun_q, err_overrun_d;
    logic          wdog_expired;

`ifdef ROWBUFF_SEQ_TIMEOUT_EN
    logic err_timeout_q, err_timeout_d;

    rowbuff_seq_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .run    (state_q == WAIT_SET),
        .expired(wdog_expired)
    );

    assign err_timeout = err_timeout_q;
`else
    assign wdog_expired = 1'b0;
    // Constant low: without the watchdog the limit has nothing to act on.
    assign err_timeout  = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        rows_loaded_d = rows_loaded_q;
        err_overrun_d = err_overrun_q;
        buf_enable_d  = 1'b0;
        buf_dend_d    = 1'b0;
        rows_inc      = rows_loaded_q + ONE;

        // A request during an in-flight matrix queues one deep; a second one is dropped.
        if (start && (state_q != IDLE)) begin
            if (pending_q) begin
                err_overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start || pending_q) begin
                    state_d       = LOAD;
                    rows_loaded_d = '0;
                    pending_d     = start && pending_q;
                end
            end
            LOAD: begin
                if (bus.row_valid && row_ready_q) begin
                    buf_enable_d  = 1'b1;
                    rows_loaded_d = rows_inc;
                    if (bus.row_last || (rows_inc == FULL_COUNT)) begin
                        state_d = FLUSH;
                    end
                end
            end
            // The flush pulse lands one cycle after the last row's enable, never on top of it.
            FLUSH: begin
                buf_enable_d = 1'b1;
                buf_dend_d   = 1'b1;
                state_d      = WAIT_SET;
            end
            WAIT_SET: begin
                if (bus.buf_dset) begin
                    state_d = HANDOFF;
                end else if (wdog_expired) begin
                    state_d = IDLE;
                end
            end
            HANDOFF:  state_d = WAIT_MAT;
            WAIT_MAT: begin
                if (bus.mat_done) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase

        row_ready_d = (state_d == LOAD);
        mat_start_d = (state_d == HANDOFF);
        busy_d      = (state_d != IDLE);

`ifdef ROWBUFF_SEQ_TIMEOUT_EN
        err_timeout_d = err_timeout_q
                     || ((state_q == WAIT_SET) && !bus.buf_dset && wdog_expired);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            rows_loaded_q <= '0;
            row_ready_q   <= 1'b0;
            buf_enable_q  <= 1'b0;
            buf_dend_q    <= 1'b0;
            mat_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef ROWBUFF_SEQ_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            rows_loaded_q <= rows_loaded_d;
            row_ready_q   <= row_ready_d;
            buf_enable_q  <= buf_enable_d;
            buf_dend_q    <= buf_dend_d;
            mat_start_q   <= mat_start_d;
            busy_q        <= busy_d;
            err_overrun_q <= err_overrun_d;
`ifdef ROWBUFF_SEQ_TIMEOUT_EN
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign bus.row_ready  = row_ready_q;
    assign bus.buf_enable = buf_enable_q;
    assign bus.buf_dend   = buf_dend_q;
    assign bus.mat_start  = mat_start_q;
    assign busy           = busy_q;
    assign rows_loaded    = rows_loaded_q;
    assign err_overrun    = err_overrun_q;

endmodule

// File: tb/tb_rowbuff_seq_ctrl.sv
// Testbench for rowbuff_seq_ctrl with COLUMN_SIZE=8, TIMEOUT_CYCLES=16.
// The watchdog scenario runs only when ROWBUFF_SEQ_TIMEOUT_EN is defined.
module tb_rowbuff_seq_ctrl;

    localparam int N  = 8;
    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic [3:0] rows_loaded;
    logic       err_overrun;
    logic       err_timeout;

    rowbuff_seq_ctrl_if bus ();

    rowbuff_seq_ctrl #(
        .COLUMN_SIZE   (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .rows_loaded(rows_loaded),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction monitor: counts pulses and checks each row enable follows an accepted beat.
    int   mon_en   = 0;
    int   mon_dend = 0;
    int   mon_ms   = 0;
    logic prev_beat = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            prev_beat = 1'b0;
        end else begin
            chk("enable_follows_beat", 32'(bus.buf_enable && !bus.buf_dend), 32'(prev_beat));
            chk("dend_without_enable", 32'(bus.buf_dend && !bus.buf_enable), 0);
            if (bus.buf_enable && !bus.buf_dend) mon_en++;
            if (bus.buf_dend) mon_dend++;
            if (bus.mat_start) mon_ms++;
            prev_beat = bus.row_valid && bus.row_ready;
        end
    end

    int en0, dend0, ms0;

    task automatic snap();
        en0   = mon_en;
        dend0 = mon_dend;
        ms0   = mon_ms;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rows_loaded"}, rows_loaded, 0);
        chk({tag, "_row_ready"}, bus.row_ready, 0);
        chk({tag, "_buf_enable"}, bus.buf_enable, 0);
        chk({tag, "_buf_dend"}, bus.buf_dend, 0);
        chk({tag, "_mat_start"}, bus.mat_start, 0);
        chk({tag, "_err_overrun"}, err_overrun, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic do_start();
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", bus.row_ready, 1);
        chk("start_rows_clear", rows_loaded, 0);
    endtask

    // Source: vmode 0 back-to-back, 1 every other cycle, 2 random valid.
    task automatic load_rows(input int last_at, input int vmode, input int exp_rows);
        int   acc;
        int   cyc;
        logic v;
        acc = 0;
        cyc = 0;
        while (cyc < 100) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.row_valid = v;
            bus.row_last  = v && (last_at != 0) && ((acc + 1) == last_at);
            if (v && bus.row_ready) acc++;
            tick();
            cyc++;
            if (!bus.row_ready) break;
        end
        bus.row_valid = 1'b0;
        bus.row_last  = 1'b0;
        chk("load_bound", 32'(cyc < 100), 1);
        chk("beats_accepted", acc, exp_rows);
        chk("rows_loaded", rows_loaded, exp_rows);
        chk("last_beat_en", {bus.buf_enable, bus.buf_dend}, 2);
    endtask

    task automatic flush_handoff(input int exp_rows, input int dly);
        tick();
        chk("flush_en_dend", {bus.buf_enable, bus.buf_dend}, 3);
        chk("flush_ready", bus.row_ready, 0);
        chk("en_pulses", mon_en - en0, exp_rows);
        repeat (dly) begin
            tick();
            chk("wait_set_en", bus.buf_enable, 0);
            chk("wait_set_mstart", bus.mat_start, 0);
        end
        bus.buf_dset = 1'b1;
        tick();
        bus.buf_dset = 1'b0;
        chk("mat_start", bus.mat_start, 1);
        tick();
        chk("mat_start_once", bus.mat_start, 0);
        chk("wait_mat_busy", busy, 1);
    endtask

    task automatic finish_mat(input int exp_rows);
        bus.mat_done = 1'b1;
        tick();
        bus.mat_done = 1'b0;
        chk("done_busy", busy, 0);
        chk("done_rows", rows_loaded, exp_rows);
        chk("mat_start_count", mon_ms - ms0, 1);
        chk("dend_count", mon_dend - dend0, 1);
    endtask

    typedef struct {
        int last_at;
        int vmode;
        int dset_dly;
        int exp_rows;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{0, 0, 2, 8};  // full matrix, back-to-back
        vecs[1] = '{3, 0, 2, 3};  // short matrix
        vecs[2] = '{0, 1, 1, 8};  // throttled source
        vecs[3] = '{1, 0, 0, 1};  // one-row matrix
        vecs[4] = '{8, 1, 3, 8};  // row_last on the final full row
        vecs[5] = '{5, 2, 4, 5};  // random valid, short

        bus.row_valid = 1'b0;
        bus.row_last  = 1'b0;
        bus.buf_dset  = 1'b0;
        bus.mat_done  = 1'b0;

        #2 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();
        chk_all_zero("after_reset");

        for (int i = 0; i < 6; i++) begin
            do_start();
            load_rows(vecs[i].last_at, vecs[i].vmode, vecs[i].exp_rows);
            flush_handoff(vecs[i].exp_rows, vecs[i].dset_dly);
            finish_mat(vecs[i].exp_rows);
            $display("vector %0d: rows=%0d en=%0d", i, rows_loaded, mon_en - en0);
            tick();
        end

        // Pending request plus overrun while the matrix unit is busy.
        do_start();
        load_rows(0, 0, N);
        flush_handoff(N, 1);
        start = 1'b1;
        tick();
        chk("first_pending_no_overrun", err_overrun, 0);
        tick();
        start = 1'b0;
        chk("overrun_set", err_overrun, 1);
        bus.mat_done = 1'b1;
        tick();
        bus.mat_done = 1'b0;
        chk("pending_bubble_idle", busy, 0);
        tick();
        chk("pending_load_busy", busy, 1);
        chk("pending_load_ready", bus.row_ready, 1);
        snap();
        load_rows(0, 0, N);
        flush_handoff(N, 0);
        finish_mat(N);
        repeat (4) tick();
        chk("no_second_extra", busy, 0);
        $display("pending sequence: overrun=%0d busy=%0d", err_overrun, busy);

        // start in the same cycle as mat_done is kept as pending.
        do_start();
        load_rows(3, 0, 3);
        flush_handoff(3, 1);
        start        = 1'b1;
        bus.mat_done = 1'b1;
        tick();
        start        = 1'b0;
        bus.mat_done = 1'b0;
        chk("same_cycle_idle", busy, 0);
        tick();
        chk("same_cycle_load", bus.row_ready, 1);
        chk("overrun_sticky", err_overrun, 1);
        snap();
        load_rows(2, 0, 2);
        flush_handoff(2, 2);
        finish_mat(2);
        $display("same-cycle start/done: rows=%0d", rows_loaded);

        // Randomized matrices against the row-count rule: first row_last, else COLUMN_SIZE.
        for (int m = 0; m < 12; m++) begin
            int la;
            int exp_rows;
            int dly;
            la       = $urandom_range(0, N);
            exp_rows = (la == 0) ? N : la;
            dly      = $urandom_range(0, 4);
            repeat ($urandom_range(0, 3)) tick();
            do_start();
            load_rows(la, 2, exp_rows);
            flush_handoff(exp_rows, dly);
            finish_mat(exp_rows);
            $display("random %0d: last_at=%0d rows=%0d en=%0d", m, la, rows_loaded, mon_en - en0);
        end

        // Reset in the middle of LOAD.
        do_start();
        bus.row_valid = 1'b1;
        repeat (4) tick();
        chk("mid_load_rows", rows_loaded, 4);
        #2 reset = 1'b0;
        bus.row_valid = 1'b0;
        #1 chk_all_zero("mid_load_reset");
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
        repeat (6) begin
            tick();
            chk("post_reset_busy", busy, 0);
        end
        chk("post_reset_no_dend", mon_dend - dend0, 0);
        chk("post_reset_no_mstart", mon_ms - ms0, 0);
        $display("reset mid-load: busy=%0d rows=%0d", busy, rows_loaded);

`ifdef ROWBUFF_SEQ_TIMEOUT_EN
        // Watchdog: no buf_dset for TO cycles; a pending request survives the timeout.
        do_start();
        load_rows(0, 0, N);
        tick();
        chk("to_flush", {bus.buf_enable, bus.buf_dend}, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TO - 2) tick();
        chk("to_not_yet", err_timeout, 0);
        chk("to_still_busy", busy, 1);
        tick();
        chk("to_flag", err_timeout, 1);
        chk("to_idle", busy, 0);
        chk("to_no_mstart", mon_ms - ms0, 0);
        tick();
        chk("to_pending_load", bus.row_ready, 1);
        snap();
        load_rows(2, 0, 2);
        flush_handoff(2, 1);
        finish_mat(2);
        chk("to_sticky", err_timeout, 1);
        $display("timeout sequence: err_timeout=%0d", err_timeout);
`else
        chk("timeout_tied_low", err_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
